multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/alu.sv | 36 +++
 rtl/regfile_param.sv | 39 +++
 rtl/multicycle_datapath.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32 datapath.
// Holds opcode/funct3/funct7 constants, the 4-bit ALU control codes
// ({alt-bit, funct3}), the FSM state encoding and the decoded
// instruction class.
// Configuration macro BRANCH_FULL_EN is consumed by multicycle_datapath.
package riscv_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control: MSB selects the alternate (sub / arithmetic shift) form,
    // low bits mirror funct3 so OP/OP_IMM map directly.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        K_OP, K_OP_IMM, K_LOAD, K_STORE, K_BRANCH, K_ILLEGAL
    } kind_t;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU.
// Ports:
//   ctrl   - 4-bit ALU control code (riscv_pkg ALU_*)
//   a, b   - operands
//   result - operation result
//   zero   - result == 0 (used for beq/bne)
module alu
    import riscv_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/regfile_param.sv
// Parameterised integer register file (16 for RV32E, 32 for RV32I).
// Ports:
//   clk            - clock
//   rst            - synchronous active-low clear of every register
//   raddr1/rdata1  - asynchronous read port 1
//   raddr2/rdata2  - asynchronous read port 2
//   we/waddr/wdata - synchronous write port; writes to x0 are dropped
module regfile_param #(
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] regs [NUM_REGS];

    // x0 stays zero because it is cleared on reset and never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32 integer datapath: IF -> ID -> EX -> [MEM] -> [WB].
// Supports OP, OP_IMM, lw, sw and conditional branches.
// Configuration: define BRANCH_FULL_EN to support bne/blt/bge/bltu/bgeu;
// without it only beq is accepted and other branch funct3 values trap.
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   iReq/iAck/instr  - instruction fetch handshake (instr valid with iAck)
//   PC               - program counter / fetch address
//   dReq/dWe/dAck    - data memory handshake (dReadData valid with dAck)
//   dAddress, dWriteData, dReadData - data memory bus
//   retire           - one-cycle pulse after each completed instruction
//   illegal          - sticky trap flag
module multicycle_datapath
    import riscv_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = 32'h00400000,
    parameter int          NUM_REGS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        iReq,
    input  logic        iAck,
    input  logic [31:0] instr,
    output logic [31:0] PC,
    output logic        dReq,
    output logic        dWe,
    input  logic        dAck,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    input  logic [31:0] dReadData,
    output logic        retire,
    output logic        illegal
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS6 = 6'(NUM_REGS);

    state_t      state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;

    // Instruction fields
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic [31:0] imm_i, imm_s, imm_b, shamt;
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign shamt = {27'b0, ir[24:20]};

    kind_t       kind;
    logic [3:0]  alu_ctrl;
    logic        use_imm, uses_rd, uses_rs2, reg_bad;
    logic [31:0] imm;

    always_comb begin
        kind     = K_ILLEGAL;
        alu_ctrl = ALU_ADD;
        use_imm  = 1'b0;
        imm      = imm_i;
        uses_rd  = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rd  = 1'b1;
                uses_rs2 = 1'b1;
                alu_ctrl = {ir[30], f3};
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR)))
                    kind = K_OP;
            end
            OPC_OP_IMM: begin
                uses_rd = 1'b1;
                use_imm = 1'b1;
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    // Shift amounts are zero-extended; ir[30] picks srai.
                    imm      = shamt;
                    alu_ctrl = {ir[30], f3};
                    if (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SR))
                        kind = K_OP_IMM;
                end else begin
                    alu_ctrl = {1'b0, f3};
                    kind     = K_OP_IMM;
                end
            end
            OPC_LOAD: begin
                uses_rd = 1'b1;
                use_imm = 1'b1;
                if (f3 == F3_LW) kind = K_LOAD;
            end
            OPC_STORE: begin
                uses_rs2 = 1'b1;
                use_imm  = 1'b1;
                imm      = imm_s;
                if (f3 == F3_SW) kind = K_STORE;
            end
            OPC_BRANCH: begin
                uses_rs2 = 1'b1;
                imm      = imm_b;
                // Equality via SUB/zero, ordering via SLT/SLTU bit 0.
                alu_ctrl = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
`ifdef BRANCH_FULL_EN
                if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT ||
                    f3 == F3_BGE || f3 == F3_BLTU || f3 == F3_BGEU)
                    kind = K_BRANCH;
`else
                if (f3 == F3_BEQ) kind = K_BRANCH;
`endif
            end
            default: kind = K_ILLEGAL;
        endcase
    end

    assign reg_bad = (uses_rd && ({1'b0, rd} >= NREGS6)) ||
                     ({1'b0, rs1} >= NREGS6) ||
                     (uses_rs2 && ({1'b0, rs2} >= NREGS6));

    logic [31:0] rdata1, rdata2, wdata, alu_b, alu_result;
    logic        alu_zero, taken, we;

    assign we    = (state == ST_WB);
    assign wdata = (kind == K_LOAD) ? mdr : alu_out;

    regfile_param #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1[AW-1:0]),
        .rdata1 (rdata1),
        .raddr2 (rs2[AW-1:0]),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (rd[AW-1:0]),
        .wdata  (wdata)
    );

    assign alu_b = use_imm ? imm : b_reg;

    alu u_alu (
        .ctrl   (alu_ctrl),
        .a      (a_reg),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

`ifdef BRANCH_FULL_EN
    // funct3[0] inverts the sense: bne/bge/bgeu are negations.
    assign taken = f3[0] ^ (f3[2] ? alu_result[0] : alu_zero);
`else
    assign taken = alu_zero;
`endif

    logic [31:0] pc_plus4, branch_target;
    assign pc_plus4      = PC + 32'd4;
    assign branch_target = PC + imm;

    assign dAddress   = alu_out;
    assign dWriteData = b_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IF;
            PC      <= INITIAL_PC;
            iReq    <= 1'b0;
            dReq    <= 1'b0;
            dWe     <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_IF: begin
                    // Right after reset iReq is low; raise it first so a
                    // stale acknowledge is never taken.
                    if (!iReq) begin
                        iReq <= 1'b1;
                    end else if (iAck) begin
                        ir    <= instr;
                        iReq  <= 1'b0;
                        state <= ST_ID;
                    end
                end
                ST_ID: begin
                    a_reg <= rdata1;
                    b_reg <= rdata2;
                    if (kind == K_ILLEGAL || reg_bad) begin
                        illegal <= 1'b1;
                        state   <= ST_TRAP;
                    end else begin
                        state <= ST_EX;
                    end
                end
                ST_EX: begin
                    alu_out <= alu_result;
                    case (kind)
                        K_BRANCH: begin
                            PC     <= taken ? branch_target : pc_plus4;
                            retire <= 1'b1;
                            iReq   <= 1'b1;
                            state  <= ST_IF;
                        end
                        K_LOAD, K_STORE: begin
                            dReq  <= 1'b1;
                            dWe   <= (kind == K_STORE);
                            state <= ST_MEM;
                        end
                        default: state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dReq && dAck) begin
                        dReq <= 1'b0;
                        dWe  <= 1'b0;
                        if (dWe) begin
                            PC     <= pc_plus4;
                            retire <= 1'b1;
                            iReq   <= 1'b1;
                            state  <= ST_IF;
                        end else begin
                            mdr   <= dReadData;
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    PC     <= pc_plus4;
                    retire <= 1'b1;
                    iReq   <= 1'b1;
                    state  <= ST_IF;
                end
                ST_TRAP: begin
                    iReq    <= 1'b0;
                    dReq    <= 1'b0;
                    illegal <= 1'b1;
                end
                default: begin
                    illegal <= 1'b1;
                    state   <= ST_TRAP;
                end
            endcase
        end
    end

endmodule
